operand_reg_bank: RTL

Parametrised multi-channel operand holding stage for the multicycle datapath, placed between register-file read and the ALU/execute stage. It captures NCH operands of WIDTH bits as one bundle and presents them with a valid/ready handshake. A 2-entry buffer (main + skid) lets the producer stream without a combinational ready path while execute stalls. Synchronous flush discards in-flight bundles.

---
 rtl/operand_reg_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/operand_reg_bank.sv
// Operand holding stage between register-file read and execute.
// Two-entry buffer (main + skid) with registered valid/ready and synchronous flush.
module operand_reg_bank #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
);

    localparam int DW = NCH * WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [DW-1:0] main_r;
    logic [DW-1:0] skid_r;
    logic [DW-1:0] main_nxt_s;
    logic [DW-1:0] skid_nxt_s;
    logic          accept_s;
    logic          emit_s;

    // Handshake flags are decoded from registered state only, so ready never
    // depends combinationally on the consumer.
    assign in_ready  = (state_r != FULL);
    assign out_valid = (state_r != EMPTY);
    assign occupancy = state_r;
    assign out_data  = main_r;
    assign accept_s  = in_valid & in_ready;
    assign emit_s    = out_valid & out_ready;

    // Next-state and data-path selection; flush overrides and leaves data untouched.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !emit_s) begin
                        state_nxt_s = FULL;
                        skid_nxt_s  = in_data;
                    end else if (emit_s && !accept_s) begin
                        state_nxt_s = EMPTY;
                    end else if (accept_s && emit_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    if (emit_s) begin
                        state_nxt_s = ONE;
                        main_nxt_s  = skid_r;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            main_r  <= {DW{1'b0}};
            skid_r  <= {DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
        end
    end

endmodule
